// File: rtl/hw_nios_onchip_mem_burst_adapter.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM.
// Optional boundary checking: define BURST_BOUNDARY_CHECK_EN.
module hw_nios_onchip_mem_burst_adapter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [BURST_W-1:0]    s_burstcount,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [DATA_W-1:0]     s_writedata,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
`ifdef BURST_BOUNDARY_CHECK_EN
  output logic                  burst_err,
`endif
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  input  logic [DATA_W-1:0]     m_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = ADDR_W + BURST_W;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_ISSUE,
    RD_DRAIN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [BURST_W-1:0]  rem;
  logic [BURST_W-1:0]  cnt;
  logic                flag_in;
  logic                flag_q;
  logic                rd_p1;
  logic                rd_p2;
  logic                err_p1;
  logic                err_p2;

  // A burstcount of zero means a single beat
  assign cnt = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

`ifdef BURST_BOUNDARY_CHECK_EN
  logic [SW-1:0] end_sum;
  assign end_sum = SW'(s_address) + SW'(cnt);
  // Burst would run past the top of memory
  assign flag_in = end_sum > (SW'(1) << ADDR_W);
`else
  assign flag_in = 1'b0;
`endif

  // Stall only while a read burst owns the RAM, or during reset
  assign s_waitrequest = reset
                       | (state == RD_ISSUE)
                       | (state == RD_DRAIN);

  // Burst FSM, RAM-side strobes and the read-return pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      addr            <= '0;
      rem             <= '0;
      flag_q          <= 1'b0;
      rd_p1           <= 1'b0;
      rd_p2           <= 1'b0;
      err_p1          <= 1'b0;
      err_p2          <= 1'b0;
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
      m_address       <= '0;
      m_byteenable    <= '0;
      m_chipselect    <= 1'b0;
      m_write         <= 1'b0;
      m_writedata     <= '0;
`ifdef BURST_BOUNDARY_CHECK_EN
      burst_err       <= 1'b0;
`endif
    end else begin
      m_chipselect    <= 1'b0;
      m_write         <= 1'b0;
      rd_p1           <= 1'b0;
      err_p1          <= 1'b0;
      rd_p2           <= rd_p1;
      err_p2          <= err_p1;
      s_readdatavalid <= rd_p2;
      if (rd_p2) begin
        s_readdata <= err_p2 ? DATA_W'(32'hDEAD_BEEF) : m_readdata;
      end
      unique case (state)
        IDLE: begin
          if (s_write) begin
            m_address    <= s_address;
            m_byteenable <= s_byteenable;
            m_writedata  <= s_writedata;
            m_write      <= !flag_in;
            m_chipselect <= !flag_in;
            addr         <= s_address + 1'b1;
            rem          <= cnt - 1'b1;
            flag_q       <= flag_in;
            if (cnt != BURST_W'(1)) state <= WR_BURST;
          end else if (s_read) begin
            addr   <= s_address;
            rem    <= cnt;
            flag_q <= flag_in;
            state  <= RD_ISSUE;
          end
`ifdef BURST_BOUNDARY_CHECK_EN
          if ((s_write || s_read) && flag_in) burst_err <= 1'b1;
`endif
        end
        WR_BURST: begin
          if (s_write) begin
            m_address    <= addr;
            m_byteenable <= s_byteenable;
            m_writedata  <= s_writedata;
            m_write      <= !flag_q;
            m_chipselect <= !flag_q;
            addr         <= addr + 1'b1;
            rem          <= rem - 1'b1;
            if (rem == BURST_W'(1)) state <= IDLE;
          end
        end
        RD_ISSUE: begin
          m_address    <= addr;
          m_byteenable <= '1;
          m_chipselect <= !flag_q;
          rd_p1        <= 1'b1;
          err_p1       <= flag_q;
          addr         <= addr + 1'b1;
          rem          <= rem - 1'b1;
          if (rem == BURST_W'(1)) state <= RD_DRAIN;
        end
        RD_DRAIN: begin
          if (s_readdatavalid && !rd_p1 && !rd_p2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
